spi_slave_shifter: RTL and testbench
====================================

Name: spi_slave_shifter

Overview:
- Mode-0 (CPOL=0, CPHA=0) SPI slave shift engine.
- Sits directly downstream of the SCK/SS edge detectors. It consumes their single-cycle edge pulses plus the synchronized MOSI level.
- Deserializes MOSI into words and serializes a buffered transmit word onto MISO.
- Presents a simple valid/ready interface to the system side, all in the `clk` domain.

Parameters:
- WIDTH, 8, bits per SPI word (legal range 2..32).

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  synchronous active-high reset.
- ss_active  input  1  synchronized SS_n, inverted (1 = slave selected).
- ss_start  input  1  one-cycle pulse on SS_n falling edge.
- sck_rise  input  1  one-cycle pulse on synchronized SCK rising edge.
- sck_fall  input  1  one-cycle pulse on synchronized SCK falling edge.
- mosi  input  1  synchronized MOSI level.
- miso  output  1  registered MISO drive.
- tx_data  input  WIDTH  word to transmit.
- tx_valid  input  1  tx_data valid.
- tx_ready  output  1  transmit holding buffer empty.
- rx_data  output  WIDTH  last completed received word.
- rx_valid  output  1  one-cycle pulse, rx_data updated.
- tx_underrun  output  1  one-cycle pulse, word load found buffer empty.

Behaviour:
- Reset values: miso=0, rx_data=0, rx_valid=0, tx_underrun=0, tx_ready=1 (buffer empty), state=IDLE, bit_cnt=0, shift registers=0.
- Transmit buffer:
  - One WIDTH-bit holding register; tx_ready = ~buf_full, driven directly from the register.
  - Write occurs when tx_valid & tx_ready, and sets buf_full next cycle.
  - Buffer write is legal in any state.
- States: IDLE, ACTIVE.
- IDLE -> ACTIVE on ss_start:
  - bit_cnt<=0.
  - tx_shift<=buffer if buf_full (buffer cleared), else all-ones with tx_underrun pulsed.
  - miso<=MSB of the loaded word, so the first bit is valid before the first SCK rise.
- ACTIVE, on sck_rise:
  - rx_shift<={rx_shift[WIDTH-2:0], mosi}; bit_cnt increments.
  - When bit_cnt==WIDTH-1: rx_data<={rx_shift[WIDTH-2:0], mosi}, rx_valid=1 for one cycle, bit_cnt wraps to 0, word_done flag set.
  - rx_valid asserts exactly 1 clk after the final sck_rise pulse.
  - rx_data holds its value until the next completed word.
  - No backpressure: the consumer must take it on the pulse.
- ACTIVE, on sck_fall:
  - If word_done is set: reload tx_shift from buffer (same underrun rule as at ss_start), miso<=new MSB, clear word_done.
  - Otherwise: tx_shift<<1 and miso<=next bit (tx_shift[WIDTH-2]).
  - A fall that precedes any rise in the frame (stray fall) is ignored.
- ACTIVE -> IDLE when ss_active==0:
  - Partial word discarded, no rx_valid.
  - bit_cnt<=0, word_done<=0, miso<=0.
  - Buffer contents kept.
- ss_start while already ACTIVE: restart the frame exactly as the IDLE -> ACTIVE entry.
- sck pulses while IDLE are ignored.
- Priority when pulses coincide: rst > ss_active low > ss_start > sck_rise > sck_fall. A sck_fall coinciding with sck_rise is dropped.
- Buffer consumption and a new write never coincide, because a write requires buf_full=0. A write in the same cycle as a load that finds the buffer empty still counts as an underrun; the written word is kept for the next load.
- Reset mid-frame returns every output to its reset value on the next clk edge.

Test Plan:
- Single byte: buffer 0xA5; ss_start, then 8 rise/fall pairs with MOSI=0x3C MSB-first. Required: MISO sequence 1,0,1,0,0,1,0,1; rx_data=0x3C with rx_valid for one cycle, 1 clk after the 8th rise; tx_ready=1 after ss_start.
- Back-to-back: buffer 0x81, then write 0x7E during word 1; 16 SCK periods. Required: MISO carries 0x81 then 0x7E; two rx_valid pulses, 8 rises apart.
- Underrun: ss_start with an empty buffer. Required: tx_underrun pulses once; MISO=1 for all 8 bits; RX unaffected.
- Abort: ss_active deasserted after 5 rises. Required: no rx_valid, miso=0 next cycle. A following full frame with MOSI=0xC3 yields rx_data=0xC3 with no residue from the aborted frame.
- Priority: sck_rise and ss_active=0 in the same cycle. Required: IDLE next cycle, no bit shifted. Separately, sck_rise and sck_fall in the same cycle: only the rise takes effect.
- Reset mid-frame: assert rst after 3 bits with buffer full. Required: next cycle miso=0, tx_ready=1, rx_valid=0, state IDLE.

Source files
------------

// File: rtl/spi_slave_shifter.sv
// ---------------------------------------------------------------------------
// spi_slave_shifter
//   Mode-0 (CPOL=0, CPHA=0) SPI slave shift engine. Consumes the one-cycle
//   SCK/SS edge pulses and the synchronized MOSI level. It deserializes MOSI
//   into WIDTH-bit words and serializes a buffered transmit word onto MISO.
//   All logic runs on posedge clk.
//
// Ports
//   clk, rst     system clock and synchronous active-high reset
//   ss_active    1 = slave selected (synchronized, inverted SS_n)
//   ss_start     one-cycle pulse on the SS_n falling edge
//   sck_rise     one-cycle pulse on the synchronized SCK rising edge
//   sck_fall     one-cycle pulse on the synchronized SCK falling edge
//   mosi         synchronized MOSI level
//   miso         registered MISO drive
//   tx_data      word to transmit; written when tx_valid & tx_ready
//   tx_valid     tx_data valid
//   tx_ready     transmit holding buffer is empty
//   rx_data      last completed received word
//   rx_valid     one-cycle pulse when rx_data updates (no backpressure)
//   tx_underrun  one-cycle pulse when a word load found the buffer empty
//   fsm_state    debug view of the FSM (0 = IDLE, 1 = ACTIVE)
//
// Handshake: a transmit word transfers on any clk edge where tx_valid and
// tx_ready are both high; tx_valid may be asserted at any time and tx_data
// must be stable while tx_valid is high. rx_valid is a strobe with no ready.
// ---------------------------------------------------------------------------
module spi_slave_shifter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ss_active,
  input  logic             ss_start,
  input  logic             sck_rise,
  input  logic             sck_fall,
  input  logic             mosi,
  output logic             miso,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  output logic             tx_underrun,
  output logic             fsm_state
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

  state_t           state;
  state_t           state_next;

  logic [CW-1:0]    bit_cnt;
  logic [WIDTH-1:0] rx_shift;
  logic [WIDTH-1:0] tx_shift;
  logic [WIDTH-1:0] tx_buf;
  logic             buf_full;
  logic             word_done;
  logic             seen_rise;

  // Decoded per-cycle actions (mutually exclusive by priority).
  logic             do_abort;
  logic             do_start;
  logic             do_rise;
  logic             do_fall;
  logic             do_load;
  logic             do_write;
  logic             last_bit;
  logic [WIDTH-1:0] load_word;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic. A restart while ACTIVE simply stays ACTIVE.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (ss_start)   state_next = ACTIVE;
      ACTIVE:  if (!ss_active) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Action decode. Priority: deselect > ss_start > sck_rise > sck_fall.
  // A fall before any rise in the frame is a stray edge and is ignored.
  always_comb begin
    do_abort  = (state == ACTIVE) && !ss_active;
    do_start  = ss_start && !do_abort;
    do_rise   = (state == ACTIVE) && !do_abort && !ss_start && sck_rise;
    do_fall   = (state == ACTIVE) && !do_abort && !ss_start && !sck_rise &&
                sck_fall && seen_rise;
    do_load   = do_start || (do_fall && word_done);
    do_write  = tx_valid && !buf_full;
    last_bit  = (bit_cnt == CW'(WIDTH - 1));
    // An empty buffer transmits all-ones.
    load_word = buf_full ? tx_buf : '1;
  end

  assign tx_ready  = ~buf_full;
  assign fsm_state = state;

  // Datapath.
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt     <= '0;
      rx_shift    <= '0;
      tx_shift    <= '0;
      tx_buf      <= '0;
      buf_full    <= 1'b0;
      word_done   <= 1'b0;
      seen_rise   <= 1'b0;
      miso        <= 1'b0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      tx_underrun <= 1'b0;
    end else begin
      rx_valid    <= 1'b0;
      tx_underrun <= 1'b0;

      // A load that finds the buffer empty never clears it, so a write
      // landing in the same cycle is kept for the next load.
      if (do_write) begin
        tx_buf   <= tx_data;
        buf_full <= 1'b1;
      end else if (do_load) begin
        buf_full <= 1'b0;
      end

      if (do_abort) begin
        bit_cnt   <= '0;
        rx_shift  <= '0;
        word_done <= 1'b0;
        seen_rise <= 1'b0;
        miso      <= 1'b0;
      end else if (do_start) begin
        bit_cnt     <= '0;
        rx_shift    <= '0;
        word_done   <= 1'b0;
        seen_rise   <= 1'b0;
        tx_shift    <= load_word;
        miso        <= load_word[WIDTH-1];
        tx_underrun <= ~buf_full;
      end else if (do_rise) begin
        seen_rise <= 1'b1;
        rx_shift  <= {rx_shift[WIDTH-2:0], mosi};
        if (last_bit) begin
          rx_data   <= {rx_shift[WIDTH-2:0], mosi};
          rx_valid  <= 1'b1;
          bit_cnt   <= '0;
          word_done <= 1'b1;
        end else begin
          bit_cnt <= bit_cnt + 1'b1;
        end
      end else if (do_fall) begin
        if (word_done) begin
          tx_shift    <= load_word;
          miso        <= load_word[WIDTH-1];
          tx_underrun <= ~buf_full;
          word_done   <= 1'b0;
        end else begin
          tx_shift <= tx_shift << 1;
          miso     <= tx_shift[WIDTH-2];
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_slave_shifter.sv
// ---------------------------------------------------------------------------
// tb_spi_slave_shifter
//   Self-checking bench for spi_slave_shifter. Frames are built from
//   random (or fixed) words; expected MISO bits, received words and underrun
//   pulses come from a word-level model of the holding buffer.
// ---------------------------------------------------------------------------
module tb_spi_slave_shifter;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         ss_active = 1'b0;
  logic         ss_start = 1'b0;
  logic         sck_rise = 1'b0;
  logic         sck_fall = 1'b0;
  logic         mosi = 1'b0;
  logic         miso;
  logic [W-1:0] tx_data = '0;
  logic         tx_valid = 1'b0;
  logic         tx_ready;
  logic [W-1:0] rx_data;
  logic         rx_valid;
  logic         tx_underrun;
  logic         fsm_state;

  int checks = 0;
  int failures = 0;

  // Buffer model: holds at most one pending transmit word.
  logic [W-1:0] exp_q[$];

  spi_slave_shifter #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .ss_active(ss_active), .ss_start(ss_start),
    .sck_rise(sck_rise), .sck_fall(sck_fall), .mosi(mosi), .miso(miso),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .tx_underrun(tx_underrun),
    .fsm_state(fsm_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Driver tasks
  task automatic write_word(input logic [W-1:0] w);
    checks++;
    if (tx_ready !== (exp_q.size() == 0)) begin
      failures++;
      $display("FAIL tx_ready_before_write: got %b expected %b", tx_ready, exp_q.size() == 0);
    end
    tx_data = w; tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    exp_q.push_back(w);
    checks++;
    if (tx_ready !== 1'b0) begin
      failures++;
      $display("FAIL tx_ready_after_write: got %b expected 0", tx_ready);
    end
  endtask

  task automatic do_rise(input logic b);
    sck_rise = 1'b1; mosi = b;
    tick();
    sck_rise = 1'b0;
  endtask

  task automatic do_fall();
    sck_fall = 1'b1;
    tick();
    sck_fall = 1'b0;
  endtask

  // Model of a word load: next buffered word, or all-ones on underrun.
  task automatic model_load(output logic [W-1:0] cur, output logic ur);
    if (exp_q.size() > 0) begin
      cur = exp_q.pop_front(); ur = 1'b0;
    end else begin
      cur = '1; ur = 1'b1;
    end
  endtask

  task automatic check_load(input string name, input logic [W-1:0] cur, input logic ur);
    checks++;
    if (tx_underrun !== ur) begin
      failures++;
      $display("FAIL %s_underrun: got %b expected %b", name, tx_underrun, ur);
    end
    checks++;
    if (miso !== cur[W-1]) begin
      failures++;
      $display("FAIL %s_miso_msb: got %b expected %b", name, miso, cur[W-1]);
    end
    checks++;
    if (tx_ready !== 1'b1) begin
      failures++;
      $display("FAIL %s_tx_ready: got %b expected 1", name, tx_ready);
    end
  endtask

  task automatic start_frame(output logic [W-1:0] cur);
    logic ur;
    ss_active = 1'b1; ss_start = 1'b1;
    tick();
    ss_start = 1'b0;
    model_load(cur, ur);
    check_load("start", cur, ur);
  endtask

  task automatic end_frame(input string name);
    ss_active = 1'b0;
    tick();
    checks++;
    if (miso !== 1'b0 || fsm_state !== 1'b0 || rx_valid !== 1'b0) begin
      failures++;
      $display("FAIL %s_end: got miso=%b state=%b rx_valid=%b expected 0/0/0", name, miso, fsm_state, rx_valid);
    end
  endtask

  // One full frame of nwords words. feed writes the next word during the
  // current word so back-to-back words flow without underrun.
  task automatic run_frame(input int nwords, input bit preload, input bit feed,
                           input bit fixed, input logic [W-1:0] tx0,
                           input logic [W-1:0] tx1, input logic [W-1:0] rx0);
    logic [W-1:0] tx_w[4];
    logic [W-1:0] rx_w[4];
    logic [W-1:0] cur;
    logic         ur;
    for (int k = 0; k < 4; k++) begin
      tx_w[k] = W'($urandom);
      rx_w[k] = W'($urandom);
    end
    if (fixed) begin
      tx_w[0] = tx0; tx_w[1] = tx1; rx_w[0] = rx0;
    end
    if (preload) write_word(tx_w[0]);
    start_frame(cur);
    for (int k = 0; k < nwords; k++) begin
      for (int i = 0; i < W; i++) begin
        checks++;
        if (miso !== cur[W-1-i]) begin
          failures++;
          $display("FAIL frame_miso: word %0d bit %0d got %b expected %b", k, i, miso, cur[W-1-i]);
        end
        if (feed && (k + 1 < nwords) && i == 2) write_word(tx_w[k+1]);
        do_rise(rx_w[k][W-1-i]);
        checks++;
        if (rx_valid !== (i == W - 1)) begin
          failures++;
          $display("FAIL frame_rx_valid: word %0d bit %0d got %b expected %b", k, i, rx_valid, i == W - 1);
        end
        if (i == W - 1) begin
          checks++;
          if (rx_data !== rx_w[k]) begin
            failures++;
            $display("FAIL frame_rx_data: word %0d got %h expected %h", k, rx_data, rx_w[k]);
          end
        end
        tick();
        checks++;
        if (rx_valid !== 1'b0) begin
          failures++;
          $display("FAIL frame_rx_pulse_len: got %b expected 0", rx_valid);
        end
        do_fall();
        if (i == W - 1) begin
          model_load(cur, ur);
          check_load("reload", cur, ur);
        end else begin
          checks++;
          if (tx_underrun !== 1'b0) begin
            failures++;
            $display("FAIL frame_no_underrun: got %b expected 0", tx_underrun);
          end
        end
      end
    end
    end_frame("frame");
  endtask

  // Scenario tasks
  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    checks++;
    if (miso !== 1'b0 || rx_data !== '0 || rx_valid !== 1'b0 ||
        tx_underrun !== 1'b0 || tx_ready !== 1'b1 || fsm_state !== 1'b0) begin
      failures++;
      $display("FAIL reset_values: got miso=%b rx_data=%h rx_valid=%b ur=%b tx_ready=%b state=%b expected 0/00/0/0/1/0",
               miso, rx_data, rx_valid, tx_underrun, tx_ready, fsm_state);
    end
    rst = 1'b0;
    tick();
    exp_q.delete();
  endtask

  task automatic test_idle_pulses();
    do_rise(1'b1);
    do_fall();
    checks++;
    if (fsm_state !== 1'b0 || miso !== 1'b0 || rx_valid !== 1'b0) begin
      failures++;
      $display("FAIL idle_pulses: got state=%b miso=%b rx_valid=%b expected 0/0/0", fsm_state, miso, rx_valid);
    end
  endtask

  task automatic test_single_byte();
    run_frame(1, 1'b1, 1'b0, 1'b1, 8'hA5, 8'h00, 8'h3C);
  endtask

  task automatic test_back_to_back();
    run_frame(2, 1'b1, 1'b1, 1'b1, 8'h81, 8'h7E, W'($urandom));
  endtask

  task automatic test_underrun();
    run_frame(1, 1'b0, 1'b0, 1'b0, '0, '0, '0);
  endtask

  task automatic test_abort();
    logic [W-1:0] cur;
    write_word(W'($urandom));
    start_frame(cur);
    for (int i = 0; i < 5; i++) begin
      do_rise(1'b1);
      checks++;
      if (rx_valid !== 1'b0) begin
        failures++;
        $display("FAIL abort_rx_valid: bit %0d got %b expected 0", i, rx_valid);
      end
      do_fall();
    end
    end_frame("abort");
    tick(); tick();
    checks++;
    if (rx_valid !== 1'b0) begin
      failures++;
      $display("FAIL abort_late_rx_valid: got %b expected 0", rx_valid);
    end
    run_frame(1, 1'b1, 1'b0, 1'b1, W'($urandom), 8'h00, 8'hC3);
  endtask

  task automatic test_priority();
    logic [W-1:0] cur;
    logic [W-1:0] w;
    // Deselect coinciding with a rise: deselect wins.
    write_word(W'($urandom));
    start_frame(cur);
    do_rise(1'b1);
    do_fall();
    sck_rise = 1'b1; ss_active = 1'b0; mosi = 1'b1;
    tick();
    sck_rise = 1'b0;
    checks++;
    if (fsm_state !== 1'b0 || miso !== 1'b0 || rx_valid !== 1'b0) begin
      failures++;
      $display("FAIL prio_deselect: got state=%b miso=%b rx_valid=%b expected 0/0/0", fsm_state, miso, rx_valid);
    end
    // Stray fall, then a coincident rise+fall: only the rise acts.
    w = W'($urandom);
    write_word(w);
    start_frame(cur);
    do_fall();
    checks++;
    if (miso !== w[W-1]) begin
      failures++;
      $display("FAIL prio_stray_fall: got %b expected %b", miso, w[W-1]);
    end
    for (int i = 0; i < W; i++) begin
      if (i == 3) sck_fall = 1'b1;
      do_rise(w[i]);
      sck_fall = 1'b0;
      checks++;
      if (miso !== w[W-1-i]) begin
        failures++;
        $display("FAIL prio_rise_fall_miso: bit %0d got %b expected %b", i, miso, w[W-1-i]);
      end
      do_fall();
      if (i == W - 1) model_load(cur, cur[0]);
    end
    checks++;
    if (rx_data !== {<<{w}}) begin
      failures++;
      $display("FAIL prio_rx_data: got %h expected %h", rx_data, {<<{w}});
    end
    end_frame("prio");
  endtask

  task automatic test_reset_mid_frame();
    logic [W-1:0] cur;
    write_word(W'($urandom));
    start_frame(cur);
    for (int i = 0; i < 3; i++) begin
      do_rise(W'($urandom) != 0);
      do_fall();
    end
    write_word(W'($urandom));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    checks++;
    if (miso !== 1'b0 || tx_ready !== 1'b1 || rx_valid !== 1'b0 ||
        fsm_state !== 1'b0 || rx_data !== '0) begin
      failures++;
      $display("FAIL reset_mid_frame: got miso=%b tx_ready=%b rx_valid=%b state=%b rx_data=%h expected 0/1/0/0/00",
               miso, tx_ready, rx_valid, fsm_state, rx_data);
    end
    ss_active = 1'b0;
    tick();
  endtask

  task automatic test_random();
    for (int n = 0; n < 8; n++) begin
      run_frame($urandom_range(1, 3), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), 1'b0, '0, '0, '0);
    end
  endtask

  // Sequence and final report
  initial begin
    test_reset();
    test_idle_pulses();
    test_single_byte();
    test_back_to_back();
    test_underrun();
    test_abort();
    test_priority();
    test_random();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
